// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes and values, credit FSM states,
// and product prices used by both coin_accumulator and money_manager.
package vm_pkg;

    typedef enum logic [1:0] {
        COIN_5  = 2'b00,
        COIN_10 = 2'b01,
        COIN_20 = 2'b10,
        COIN_50 = 2'b11
    } coin_t;

    localparam logic [7:0] COIN_VAL_5  = 8'd5;
    localparam logic [7:0] COIN_VAL_10 = 8'd10;
    localparam logic [7:0] COIN_VAL_20 = 8'd20;
    localparam logic [7:0] COIN_VAL_50 = 8'd50;

    localparam logic [7:0] PRICE_A = 8'd25;
    localparam logic [7:0] PRICE_B = 8'd50;
    localparam logic [7:0] PRICE_C = 8'd75;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    function automatic logic [7:0] coin_value(input coin_t code);
        logic [7:0] val;
        case (code)
            COIN_5:  val = COIN_VAL_5;
            COIN_10: val = COIN_VAL_10;
            COIN_20: val = COIN_VAL_20;
            default: val = COIN_VAL_50;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_accumulator_idle_timer.sv
// Idle timeout for the COLLECT state: a down-counter reloaded on every accepted
// coin, flagging expiry on the cycle whose edge must enter REFUND.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with TIMEOUT_CYCLES-1 so the terminal count lines up with the
    // TIMEOUT_CYCLES-th edge after the accepting edge.
    assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/coin_accumulator.sv
// Front-end credit stage: accumulates coins, handles cancel/timeout refunds and
// presents the settled credit downstream until the transaction completes.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no credit; first accepted coin moves to COLLECT
// ST_COLLECT | accumulating; cancel > timeout > buy_req > coin
// ST_COMMIT  | credit presented downstream, waiting for mgr_done
// ST_REFUND  | one-cycle refund pulse of the held credit, then IDLE
module coin_accumulator
    import vm_pkg::*;
#(
    parameter int MAX_CREDIT     = 200,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_type_i,
    input  logic       buy_req_i,
    input  logic       cancel_i,
    input  logic       mgr_done_i,
    output logic [7:0] money_inserted_o,
    output logic       money_valid_o,
    output logic [7:0] credit_o,
    output logic       coin_reject_o,
    output logic       refund_o,
    output logic [7:0] refund_amount_o,
    output logic       busy_o
);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] money_inserted_q, money_inserted_d;
    logic       money_valid_q, money_valid_d;
    logic       coin_reject_q, coin_reject_d;
    logic       refund_q, refund_d;
    logic [7:0] refund_amount_q, refund_amount_d;
    logic       busy_q, busy_d;

    logic [8:0] coin_sum;
    logic       coin_fits;
    logic       timer_clear;
    logic       timer_run;
    logic       timer_expired;

    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(coin_t'(coin_type_i))};
    assign coin_fits = (coin_sum <= 9'(MAX_CREDIT));
    assign timer_run = (state_q == ST_COLLECT);

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (timer_clear),
        .run_i     (timer_run),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d          = state_q;
        credit_d         = credit_q;
        money_inserted_d = 8'd0;
        money_valid_d    = 1'b0;
        coin_reject_d    = 1'b0;
        refund_d         = 1'b0;
        refund_amount_d  = 8'd0;
        timer_clear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_valid_i) begin
                    if (coin_fits) begin
                        credit_d    = coin_sum[7:0];
                        state_d     = ST_COLLECT;
                        timer_clear = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (cancel_i || timer_expired) begin
                    state_d         = ST_REFUND;
                    refund_d        = 1'b1;
                    refund_amount_d = credit_q;
                    coin_reject_d   = coin_valid_i;
                end else if (buy_req_i) begin
                    state_d          = ST_COMMIT;
                    money_valid_d    = 1'b1;
                    money_inserted_d = credit_q;
                    coin_reject_d    = coin_valid_i;
                end else if (coin_valid_i) begin
                    if (coin_fits) begin
                        credit_d    = coin_sum[7:0];
                        timer_clear = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                coin_reject_d = coin_valid_i;
                if (mgr_done_i) begin
                    state_d  = ST_IDLE;
                    credit_d = 8'd0;
                end else begin
                    money_valid_d    = 1'b1;
                    money_inserted_d = credit_q;
                end
            end
            ST_REFUND: begin
                coin_reject_d = coin_valid_i;
                state_d       = ST_IDLE;
                credit_d      = 8'd0;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = 8'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            credit_q         <= 8'd0;
            money_inserted_q <= 8'd0;
            money_valid_q    <= 1'b0;
            coin_reject_q    <= 1'b0;
            refund_q         <= 1'b0;
            refund_amount_q  <= 8'd0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            money_inserted_q <= money_inserted_d;
            money_valid_q    <= money_valid_d;
            coin_reject_q    <= coin_reject_d;
            refund_q         <= refund_d;
            refund_amount_q  <= refund_amount_d;
            busy_q           <= busy_d;
        end
    end

    assign money_inserted_o = money_inserted_q;
    assign money_valid_o    = money_valid_q;
    assign credit_o         = credit_q;
    assign coin_reject_o    = coin_reject_q;
    assign refund_o         = refund_q;
    assign refund_amount_o  = refund_amount_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with an 8-cycle idle timeout.
module tb_coin_accumulator;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       buy_req;
    logic       cancel;
    logic       mgr_done;
    logic [7:0] money_inserted;
    logic       money_valid;
    logic [7:0] credit;
    logic       coin_reject;
    logic       refund;
    logic [7:0] refund_amount;
    logic       busy;

    int checks = 0;
    int errors = 0;

    coin_accumulator #(
        .MAX_CREDIT(200),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .coin_valid_i     (coin_valid),
        .coin_type_i      (coin_type),
        .buy_req_i        (buy_req),
        .cancel_i         (cancel),
        .mgr_done_i       (mgr_done),
        .money_inserted_o (money_inserted),
        .money_valid_o    (money_valid),
        .credit_o         (credit),
        .coin_reject_o    (coin_reject),
        .refund_o         (refund),
        .refund_amount_o  (refund_amount),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        buy_req    = 1'b0;
        cancel     = 1'b0;
        mgr_done   = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got %0d want 0", credit); end
        checks++; if (money_valid !== 1'b0 || money_inserted !== 8'd0) begin errors++; $display("FAIL reset_money got mv=%0b mi=%0d want 0/0", money_valid, money_inserted); end
        checks++; if (refund !== 1'b0 || refund_amount !== 8'd0 || coin_reject !== 1'b0) begin errors++; $display("FAIL reset_pulses got ref=%0b amt=%0d rej=%0b want 0", refund, refund_amount, coin_reject); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        mgr_done = 1'b1;
        tick();
        mgr_done = 1'b0;
        checks++; if (busy !== 1'b0 || money_valid !== 1'b0) begin errors++; $display("FAIL idle_mgr_done got busy=%0b mv=%0b want 0/0", busy, money_valid); end
    endtask

    task automatic test_exact_credit();
        do_reset();
        coin(2'b10);
        checks++; if (credit !== 8'd20 || busy !== 1'b1) begin errors++; $display("FAIL exact_first_coin got credit=%0d busy=%0b want 20/1", credit, busy); end
        coin(2'b00);
        checks++; if (credit !== 8'd25 || coin_reject !== 1'b0) begin errors++; $display("FAIL exact_second_coin got credit=%0d rej=%0b want 25/0", credit, coin_reject); end
        mgr_done = 1'b1;
        tick();
        mgr_done = 1'b0;
        checks++; if (credit !== 8'd25 || money_valid !== 1'b0) begin errors++; $display("FAIL collect_mgr_done got credit=%0d mv=%0b want 25/0", credit, money_valid); end
        buy_req = 1'b1;
        tick();
        buy_req = 1'b0;
        checks++; if (money_valid !== 1'b1 || money_inserted !== 8'd25) begin errors++; $display("FAIL exact_commit got mv=%0b mi=%0d want 1/25", money_valid, money_inserted); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (money_valid !== 1'b1 || money_inserted !== 8'd25 || credit !== 8'd25) begin errors++; $display("FAIL exact_hold%0d got mv=%0b mi=%0d credit=%0d want 1/25/25", i, money_valid, money_inserted, credit); end
        end
        mgr_done = 1'b1;
        tick();
        mgr_done = 1'b0;
        checks++; if (money_valid !== 1'b0 || money_inserted !== 8'd0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL exact_done got mv=%0b mi=%0d credit=%0d busy=%0b want 0/0/0/0", money_valid, money_inserted, credit, busy); end
        checks++; if (refund !== 1'b0) begin errors++; $display("FAIL exact_no_refund got %0b want 0", refund); end
    endtask

    task automatic test_over_limit();
        logic [7:0] exp_credit [4];
        exp_credit[0] = 8'd50;
        exp_credit[1] = 8'd100;
        exp_credit[2] = 8'd150;
        exp_credit[3] = 8'd200;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            coin(2'b11);
            checks++; if (credit !== exp_credit[i] || coin_reject !== 1'b0) begin errors++; $display("FAIL b2b_coin%0d got credit=%0d rej=%0b want %0d/0", i, credit, coin_reject, exp_credit[i]); end
        end
        coin(2'b00);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd200) begin errors++; $display("FAIL over_reject got rej=%0b credit=%0d want 1/200", coin_reject, credit); end
        tick();
        checks++; if (coin_reject !== 1'b0 || credit !== 8'd200) begin errors++; $display("FAIL over_single_pulse got rej=%0b credit=%0d want 0/200", coin_reject, credit); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (refund !== 1'b1 || refund_amount !== 8'd200) begin errors++; $display("FAIL over_refund got ref=%0b amt=%0d want 1/200", refund, refund_amount); end
    endtask

    task automatic test_cancel();
        do_reset();
        coin(2'b01);
        coin(2'b01);
        checks++; if (credit !== 8'd20) begin errors++; $display("FAIL cancel_credit got %0d want 20", credit); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (refund !== 1'b1 || refund_amount !== 8'd20 || busy !== 1'b1) begin errors++; $display("FAIL cancel_refund got ref=%0b amt=%0d busy=%0b want 1/20/1", refund, refund_amount, busy); end
        tick();
        checks++; if (refund !== 1'b0 || refund_amount !== 8'd0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL cancel_after got ref=%0b amt=%0d credit=%0d busy=%0b want 0/0/0/0", refund, refund_amount, credit, busy); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (refund !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_cancel got ref=%0b busy=%0b want 0/0", refund, busy); end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        coin(2'b00);
        early = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (refund !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early got %0d early refund cycles want 0", early); end
        tick();
        checks++; if (refund !== 1'b1 || refund_amount !== 8'd5) begin errors++; $display("FAIL timeout_edge8 got ref=%0b amt=%0d want 1/5", refund, refund_amount); end
        tick();
        checks++; if (credit !== 8'd0 || busy !== 1'b0 || refund !== 1'b0) begin errors++; $display("FAIL timeout_after got credit=%0d busy=%0b ref=%0b want 0/0/0", credit, busy, refund); end

        coin(2'b00);
        for (int k = 1; k <= 6; k++) tick();
        coin(2'b00);
        checks++; if (credit !== 8'd10 || refund !== 1'b0) begin errors++; $display("FAIL restart_coin got credit=%0d ref=%0b want 10/0", credit, refund); end
        early = 0;
        for (int k = 8; k <= 14; k++) begin
            tick();
            if (refund !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL restart_early got %0d early refund cycles want 0", early); end
        tick();
        checks++; if (refund !== 1'b1 || refund_amount !== 8'd10) begin errors++; $display("FAIL restart_edge15 got ref=%0b amt=%0d want 1/10", refund, refund_amount); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        coin(2'b10);
        coin(2'b00);
        cancel     = 1'b1;
        buy_req    = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'b11;
        tick();
        idle_inputs();
        checks++; if (refund !== 1'b1 || refund_amount !== 8'd25) begin errors++; $display("FAIL simul_refund got ref=%0b amt=%0d want 1/25", refund, refund_amount); end
        checks++; if (coin_reject !== 1'b1 || money_valid !== 1'b0) begin errors++; $display("FAIL simul_reject got rej=%0b mv=%0b want 1/0", coin_reject, money_valid); end
        checks++; if (credit !== 8'd25) begin errors++; $display("FAIL simul_credit got %0d want 25", credit); end
        tick();
        checks++; if (money_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL simul_after got mv=%0b credit=%0d busy=%0b want 0/0/0", money_valid, credit, busy); end
    endtask

    task automatic test_reset_commit();
        do_reset();
        coin(2'b11);
        coin(2'b10);
        coin(2'b00);
        buy_req = 1'b1;
        tick();
        buy_req = 1'b0;
        checks++; if (money_valid !== 1'b1 || money_inserted !== 8'd75) begin errors++; $display("FAIL rc_commit got mv=%0b mi=%0d want 1/75", money_valid, money_inserted); end
        cancel = 1'b1;
        coin(2'b01);
        cancel = 1'b0;
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd75 || money_inserted !== 8'd75) begin errors++; $display("FAIL rc_coin_reject got rej=%0b credit=%0d mi=%0d want 1/75/75", coin_reject, credit, money_inserted); end
        checks++; if (refund !== 1'b0 || money_valid !== 1'b1) begin errors++; $display("FAIL rc_cancel_ignored got ref=%0b mv=%0b want 0/1", refund, money_valid); end
        reset    = 1'b1;
        mgr_done = 1'b1;
        tick();
        reset    = 1'b0;
        mgr_done = 1'b0;
        checks++; if (money_valid !== 1'b0 || money_inserted !== 8'd0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL rc_after_reset got mv=%0b mi=%0d credit=%0d busy=%0b want 0/0/0/0", money_valid, money_inserted, credit, busy); end
        checks++; if (refund !== 1'b0 || refund_amount !== 8'd0 || coin_reject !== 1'b0) begin errors++; $display("FAIL rc_no_refund got ref=%0b amt=%0d rej=%0b want 0/0/0", refund, refund_amount, coin_reject); end
        tick();
        checks++; if (refund !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rc_settled got ref=%0b busy=%0b want 0/0", refund, busy); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_exact_credit();
        test_over_limit();
        test_cancel();
        test_timeout();
        test_simultaneous();
        test_reset_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
